// File: rtl/counter_pkg.sv
// Shared constants for the accumulating counter: default width and overflow modes.
package counter_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int MODE_WRAP     = 0;
  localparam int MODE_SAT      = 1;
endpackage

// File: rtl/counter_step.sv
// Next-state logic for the counter: widened add, carry out, and wrap/clamp selection.
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] next,
  output logic             carry
);
  logic [WIDTH:0] sum;

  assign sum   = {1'b0, count} + {1'b0, step};
  assign carry = sum[WIDTH];

  generate
    if (SATURATE == MODE_SAT) begin : g_sat
      // Clamp to all-ones on carry; zero step never carries, so the value simply holds.
      assign next = carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end else begin : g_wrap
      assign next = sum[WIDTH-1:0];
    end
  endgenerate
endmodule

// File: rtl/counter.sv
// Accumulating counter: adds count_in each clock, flags overflow on wrap for one cycle.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap
);
  logic [WIDTH-1:0] next;
  logic             carry;

  counter_step #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_step (
    .count (count_out),
    .step  (count_in),
    .next  (next),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_out <= '0;
      wrap      <= 1'b0;
    end else begin
      count_out <= next;
      wrap      <= carry;
    end
  end
endmodule

// File: tb/tb_counter.sv
// Directed vector bench for counter: one wrapping and one saturating instance, WIDTH=4.
module tb_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cin_w = '0, cin_s = '0;
  logic [3:0] cnt_w, cnt_s;
  logic       wrap_w, wrap_s;
  int         vec_count = 0;
  int         miss_count = 0;

  typedef struct {
    logic       rst;
    logic [3:0] cin;
    logic [3:0] exp_cnt;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  counter #(.WIDTH(4), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .count_in(cin_w), .count_out(cnt_w), .wrap(wrap_w));
  counter #(.WIDTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .count_in(cin_s), .count_out(cnt_s), .wrap(wrap_s));

  always #5 clk = ~clk;

  function automatic void add(logic r, logic [3:0] c, logic [3:0] ec, logic ew);
    vec_t v;
    v.rst = r; v.cin = c; v.exp_cnt = ec; v.exp_wrap = ew;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [3:0] ac, logic [3:0] ec, logic aw, logic ew);
    vec_count++;
    if (ac !== ec || aw !== ew) begin
      miss_count++;
      $display("FAIL %s: count_out=%0d wrap=%0b, expected count_out=%0d wrap=%0b",
               name, ac, aw, ec, ew);
    end
  endtask

  initial begin
    // reset held with nonzero step
    add(0, 5, 0, 0); add(0, 5, 0, 0);
    // release, step by 1
    add(1, 1, 1, 0); add(1, 1, 2, 0); add(1, 1, 3, 0); add(1, 1, 4, 0); add(1, 1, 5, 0);
    // climb to 15, wrap to 0, then continue
    add(1, 10, 15, 0); add(1, 1, 0, 1); add(1, 1, 1, 0);
    // 14 + 3 -> 1 with carry
    add(1, 13, 14, 0); add(1, 3, 1, 1);
    // hold at 9 with zero step
    add(1, 8, 9, 0); add(1, 0, 9, 0); add(1, 0, 9, 0); add(1, 0, 9, 0);
    // 9+15 wraps to 8; zero step drops wrap
    add(1, 15, 8, 1); add(1, 0, 8, 0);
    // 8+15 -> 7 with carry
    add(1, 15, 7, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      cin_w = vecs[i].cin;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), cnt_w, vecs[i].exp_cnt, wrap_w, vecs[i].exp_wrap);
    end

    // saturating instance saw zero step throughout
    check("sat_idle", cnt_s, 4'd0, wrap_s, 1'b0);

    // async reset mid-cycle at count 7
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_w", cnt_w, 4'd0, wrap_w, 1'b0);
    check("async_rst_s", cnt_s, 4'd0, wrap_s, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cin_w = 4'd2;
    @(posedge clk);
    #1;
    check("post_rst", cnt_w, 4'd2, wrap_w, 1'b0);

    // saturating sequence
    @(negedge clk); cin_w = 4'd0; cin_s = 4'd14;
    @(posedge clk); #1; check("sat_14", cnt_s, 4'd14, wrap_s, 1'b0);
    @(negedge clk); cin_s = 4'd3;
    @(posedge clk); #1; check("sat_clamp", cnt_s, 4'd15, wrap_s, 1'b1);
    @(negedge clk); cin_s = 4'd1;
    @(posedge clk); #1; check("sat_hold", cnt_s, 4'd15, wrap_s, 1'b1);
    @(negedge clk); cin_s = 4'd0;
    @(posedge clk); #1; check("sat_zero", cnt_s, 4'd15, wrap_s, 1'b0);
    check("wrap_inst_hold", cnt_w, 4'd2, wrap_w, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 4, bit width of count_in, count_out and the internal count register.
REQ-002 Parameter SATURATE, default 0; 0 = modulo wrap on overflow, 1 = clamp at all-ones.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, reset=1 runs.
REQ-005 Port count_in  input  WIDTH  unsigned step value added to the count each cycle.
REQ-006 Port count_out  output  WIDTH  current count, driven directly from a register.
REQ-007 Port wrap  output  1  registered flag, high for exactly the cycle following an overflow event.

Function
REQ-008 On each rising clk edge with reset=1, count_out SHALL become count_out + count_in.
REQ-009 The sum SHALL be computed WIDTH+1 bits wide; bit WIDTH is the overflow (carry) indication.
REQ-010 With SATURATE=0, count_out SHALL take the low WIDTH bits of the sum (e.g. 15+1 -> 0, 14+3 -> 1 for WIDTH=4).
REQ-011 With SATURATE=1, on carry count_out SHALL become all-ones and stay there while count_in is nonzero.
REQ-012 wrap SHALL be 1 on the edge where the carry occurs and 0 on every edge without a carry; it SHALL never stay high longer than carry persists.
REQ-013 count_in=0 SHALL hold count_out unchanged and drive wrap to 0.
REQ-014 count_in SHALL be sampled only at the rising edge; latency from count_in change to count_out update is one clock.
REQ-015 count_in carrying X/Z is illegal stimulus; the behaviour is not required to be defined.
REQ-016 No other outputs, enables or load ports; count_in is the only way to change the count besides reset.

Reset
REQ-017 While reset=0, count_out SHALL be 0 and wrap SHALL be 0, independent of clk.
REQ-018 Assertion of reset mid-count SHALL clear outputs at once, without waiting for a clock edge.
REQ-019 On the first rising edge after reset goes to 1, count_out SHALL become 0 + count_in.
REQ-020 Reset deassertion is synchronized externally; the block has no internal reset synchronizer.

Structure
REQ-021 Package counter_pkg SHALL hold the default WIDTH constant and the overflow-mode constants (MODE_WRAP=0, MODE_SAT=1).
REQ-022 One combinational sub-module counter_step SHALL compute the next count and the carry from the current count, count_in and SATURATE.
REQ-023 The top level SHALL contain only the count register and the wrap register, plus the instantiation of counter_step.

Verification
REQ-024 Hold reset=0 for 2 cycles with count_in=5 -> count_out=0, wrap=0 throughout.
REQ-025 Release reset, count_in=1 for 5 edges -> count_out steps 1,2,3,4,5, wrap=0.
REQ-026 WIDTH=4, SATURATE=0: starting at 15, count_in=1 -> count_out=0, wrap=1 for one cycle, then count_out=1, wrap=0; starting at 14, count_in=3 -> count_out=1, wrap=1.
REQ-027 At count 9, count_in=0 for 3 edges -> count_out stays 9, wrap=0.
REQ-028 At count 7, assert reset=0 between clock edges -> count_out=0 immediately; release with count_in=2 -> next edge count_out=2.
REQ-029 SATURATE=1: starting at 14, count_in=3 -> count_out=15, wrap=1; next edge with count_in=1 -> count_out=15, wrap=1.
